xor_fault_monitor: RTL

XOR_FAULT_MONITOR -- requirements
Module: xor_fault_monitor

---
 rtl/xor_fault_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/xor_fault_monitor.sv
// Compares a target XOR gate against a reference and counts qualified fault events.
// Comparison only runs after the stimulus has been quiet for SETTLE_CYCLES cycles.
module xor_fault_monitor #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned GLITCH_MIN    = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [4:0]       a,
    input  logic             osc_en,
    input  logic             q_in,
    input  logic             arm,
    input  logic             stop,
    input  logic             clear,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [4:0]       rpt_a,
    output logic             rpt_q,
    output logic             fault_pulse,
    output logic             fault_flag,
    output logic [CNT_W-1:0] fault_count,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam int unsigned SET_W = 8;
    localparam int unsigned RUN_W = 4;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(GLITCH_MIN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MONITOR = 2'd2
    } state_t;

    state_t           st;
    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             q_meta;
    logic             q_sync;
    logic [4:0]       a_d1;
    logic [4:0]       a_d2;
    logic [SET_W-1:0] settle_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             disturb_c;
    logic             mismatch_c;
    logic             event_c;
    logic             fire_c;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n  = rst_sync[1];
    assign state      = st;
    assign disturb_c  = (a != a_d1) || osc_en;
    assign mismatch_c = q_sync != (^a_d2);
    // A run qualifies on the cycle its length reaches GLITCH_MIN.
    assign event_c    = (st == MONITOR) && !disturb_c && !stop && mismatch_c
                        && (run_cnt == (RUN_MAX - RUN_W'(1)));
    assign fire_c     = event_c && !clear;

    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            st          <= IDLE;
            q_meta      <= 1'b0;
            q_sync      <= 1'b0;
            a_d1        <= '0;
            a_d2        <= '0;
            settle_cnt  <= '0;
            run_cnt     <= '0;
            fault_pulse <= 1'b0;
            fault_flag  <= 1'b0;
            fault_count <= '0;
            overflow    <= 1'b0;
            rpt_valid   <= 1'b0;
            rpt_a       <= '0;
            rpt_q       <= 1'b0;
        end else begin
            q_meta      <= q_in;
            q_sync      <= q_meta;
            a_d1        <= a;
            a_d2        <= a_d1;
            fault_pulse <= fire_c;

            if (stop) begin
                st      <= IDLE;
                run_cnt <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        run_cnt <= '0;
                        if (arm) begin
                            st         <= SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                    SETTLE: begin
                        run_cnt <= '0;
                        if (disturb_c) begin
                            settle_cnt <= SETTLE_LD;
                        end else if (settle_cnt <= SET_W'(1)) begin
                            st         <= MONITOR;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end
                    MONITOR: begin
                        if (disturb_c) begin
                            st         <= SETTLE;
                            settle_cnt <= SETTLE_LD;
                            run_cnt    <= '0;
                        end else if (!mismatch_c) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + RUN_W'(1);
                        end
                    end
                    default: begin
                        st      <= IDLE;
                        run_cnt <= '0;
                    end
                endcase
            end

            // Sticky statistics; clear discards a coincident event.
            if (clear) begin
                fault_count <= '0;
                fault_flag  <= 1'b0;
                overflow    <= 1'b0;
            end else if (fire_c) begin
                fault_flag <= 1'b1;
                if (fault_count != '1) begin
                    fault_count <= fault_count + CNT_W'(1);
                end
                if (rpt_valid && !rpt_ready) begin
                    overflow <= 1'b1;
                end
            end

            // Record channel: a new record may replace one being accepted this edge.
            if (fire_c && (!rpt_valid || rpt_ready)) begin
                rpt_valid <= 1'b1;
                rpt_a     <= a_d2;
                rpt_q     <= q_sync;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule
